usf_modulo_folder: RTL and testbench
====================================

# usf_modulo_folder

Streaming modulo-folding encoder, the transmit-side counterpart of the USF recovery chain. It takes unbounded signed samples and folds each into [-L, L) by repeated ±2L correction, emitting the result as an offset ADC code in [0, 2L-1]. That code is the format the recovery path consumes (it subtracts L). Codes are collected into frames of FRAME_LEN and presented as a parallel array, together with per-sample fold counts as ground truth for the recovery bench and for on-FPGA loopback tests.

## Interface
- ADC_RES, 12: output code width.
- IN_RES, 16: signed input sample width.
- L, 1024: fold threshold λ; requires 2L ≤ 2^ADC_RES.
- FRAME_LEN, 8: samples per frame (J+1+EXTRA_SAMPLES in the recovery chain).
- MAX_FOLDS, 15: fold iterations allowed per sample.
- K_RES, 5: signed fold-count width; must hold ±MAX_FOLDS.

Ports:
- clk  in  1  single clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- en  in  1  acceptance enable.
- in_valid  in  1  `in_sample` is valid this cycle.
- in_ready  out  1  block can accept a sample this cycle.
- in_sample  in  IN_RES signed  unfolded sample y.
- out  out  ADC_RES × FRAME_LEN  folded codes; index 0 is the oldest sample.
- k_out  out  K_RES signed × FRAME_LEN  fold count k, where y = f + 2L·k.
- frame_valid  out  1  one-cycle pulse when a new frame is on `out` and `k_out`.
- sat  out  1  the frame on `out` contains at least one saturated sample.

## Operation
- States: IDLE, FOLD.
- IDLE: `in_ready` = en. On `in_valid & in_ready`:
  - latch `in_sample` sign-extended to IN_RES+2 bits into acc;
  - clear k;
  - go to FOLD.
- FOLD, one correction per cycle:
  - acc ≥ L: acc −= 2L, k += 1.
  - acc < −L: acc += 2L, k −= 1.
  - Otherwise, write code = acc+L (ADC_RES bits) and k to buffer[idx], increment idx, return to IDLE.
- Saturation: when |k| = MAX_FOLDS and acc is still out of range:
  - write code 2L−1 if acc ≥ L, or 0 if acc < −L;
  - write k = ±MAX_FOLDS;
  - set the frame's sat_pending bit;
  - return to IDLE.
- Boundaries: y = L folds to −L (code 0, k=+1). y = −L stays in range (code 0, k=0). y = L−1 gives code 2L−1, k=0.
- Frame completion:
  - The write to idx FRAME_LEN−1 copies the whole buffer, including this write, into the `out`/`k_out` registers.
  - `sat` ← sat_pending; sat_pending and idx are cleared.
  - `frame_valid` pulses the next cycle.
- `out`, `k_out` and `sat` hold until the next frame completes (double-buffered), so the consumer may sample them any time before the next pulse.
- `en` gates only acceptance. A sample already in FOLD always completes.
- `in_sample` is ignored unless accepted.

## Timing
- Reset values:
  - `out` and `k_out` all 0;
  - `frame_valid`, `sat`, `in_ready` 0;
  - state IDLE, idx 0, sat_pending 0.
- Reset mid-frame discards the partial buffer and any in-flight sample.
- `in_ready` may first be 1 in the cycle after reset deasserts, if en=1.
- Per-sample occupancy is 2+|k| cycles:
  - accept at cycle N;
  - |k| correction cycles;
  - the write cycle is N+1+|k|;
  - `in_ready` returns at N+2+|k|.
  - A saturated sample occupies 2+MAX_FOLDS cycles.
- `frame_valid` pulses one cycle after the last sample's write cycle.
- Maximum throughput is one sample per 2 cycles when no folds are needed.
- acc is IN_RES+2 bits wide, so no overflow is possible for any input or L.

## Test plan
- L=1024, y=300 accepted at cycle 0 → write at cycle 1: code 1324, k=0; `in_ready` high at cycle 2.
- y=2500 → one correction: code 1476 (2500−2048+1024), k=+1; write at cycle 2. y=−1025 → code 2047, k=−1.
- Boundaries: y=1024 → code 0, k=+1. y=−1024 → code 0, k=0. y=1023 → code 2047, k=0.
- Saturation: y=32767 with MAX_FOLDS=15 → code 2047, k=+15, `sat`=1 on that frame's pulse; the next frame, with all samples in range, has `sat`=0.
- Stream 8 samples of a ramp 0, 500, …, 3500 → exactly one `frame_valid` pulse. `out` = {1024, 1524, 2024, 476, 976, 1476, 1976, 428}, `k_out` = {0, 0, 0, 1, 1, 1, 1, 2}. Values hold through the next partial frame.
- Control:
  - en=0 with `in_valid` held → `in_ready` stays 0 and nothing is accepted;
  - en dropping during FOLD → the sample still completes;
  - reset after 5 samples → a fresh 8-sample frame produces a pulse containing only the new samples.

Source files
------------

// File: rtl/usf_modulo_folder.sv
// -----------------------------------------------------------------------------
// usf_modulo_folder
//
// Streaming modulo-folding encoder. Each accepted signed sample y is folded
// into [-L, L) by one +/-2L correction per cycle. The result f is emitted as
// an offset ADC code f+L in [0, 2L-1], along with the fold count k, where
// y = f + 2L*k. A sample that still lies outside the range after MAX_FOLDS
// corrections is clipped to the nearest code edge and flagged as saturated.
// Codes and fold counts are collected into frames of FRAME_LEN entries.
// Each complete frame is presented as a held, double-buffered parallel array.
//
// Ports
//   clk          single clock, all logic on posedge
//   reset        synchronous, active-high
//   en           acceptance enable (does not stall a sample already folding)
//   in_valid     in_sample is valid this cycle
//   in_ready     block can accept a sample this cycle
//   in_sample    signed unfolded sample y (IN_RES bits)
//   out          FRAME_LEN folded codes, index 0 = oldest sample of the frame
//   k_out        FRAME_LEN signed fold counts, same ordering as out
//   frame_valid  one-cycle pulse when a new frame appears on out/k_out
//   sat          the frame on out holds at least one saturated sample
// -----------------------------------------------------------------------------
module usf_modulo_folder #(
    parameter int ADC_RES   = 12,
    parameter int IN_RES    = 16,
    parameter int L         = 1024,
    parameter int FRAME_LEN = 8,
    parameter int MAX_FOLDS = 15,
    parameter int K_RES     = 5
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  en,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic signed [IN_RES-1:0]              in_sample,
    output logic        [FRAME_LEN-1:0][ADC_RES-1:0] out,
    output logic signed [FRAME_LEN-1:0][K_RES-1:0]   k_out,
    output logic                                  frame_valid,
    output logic                                  sat
);

    // Two guard bits let acc absorb one +/-2L step for any input without
    // wrapping, because 2L never exceeds the input range by more than that.
    localparam int ACC_W = IN_RES + 2;
    localparam int IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    localparam logic signed [ACC_W-1:0] L_A     = ACC_W'(L);
    localparam logic signed [ACC_W-1:0] NEG_L_A = -ACC_W'(L);
    localparam logic signed [ACC_W-1:0] TWO_L_A = ACC_W'(2 * L);
    localparam logic signed [K_RES-1:0] K_ONE   = K_RES'(1);
    localparam logic signed [K_RES-1:0] K_MAX   = K_RES'(MAX_FOLDS);
    localparam logic signed [K_RES-1:0] K_MIN   = -K_RES'(MAX_FOLDS);
    localparam logic [ADC_RES-1:0]      CODE_MAX = ADC_RES'(2 * L - 1);
    localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(FRAME_LEN - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_FOLD = 1'b1
    } state_t;

    // Offset code of an in-range folded value: f in [-L, L) maps to f+L.
    function automatic logic [ADC_RES-1:0] offset_code(
        input logic signed [ACC_W-1:0] a
    );
        return ADC_RES'(a + L_A);
    endfunction

    // Clipped code for a sample that ran out of fold iterations.
    function automatic logic [ADC_RES-1:0] clip_code(input logic hi);
        return hi ? CODE_MAX : '0;
    endfunction

    // Control state
    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             sat_pend_q, sat_pend_d;
    logic             sat_q, sat_d;
    logic             fv_q, fv_d;

    // Datapath state
    logic signed [ACC_W-1:0]                acc_q, acc_d;
    logic signed [K_RES-1:0]                k_q, k_d;
    logic [FRAME_LEN-1:0][ADC_RES-1:0]      buf_code_q, buf_code_d;
    logic signed [FRAME_LEN-1:0][K_RES-1:0] buf_k_q, buf_k_d;
    logic [FRAME_LEN-1:0][ADC_RES-1:0]      out_q, out_d;
    logic signed [FRAME_LEN-1:0][K_RES-1:0] k_out_q, k_out_d;

    // Range classification of the current accumulator
    logic above, below, at_limit, sat_hit;
    logic wr;
    logic [ADC_RES-1:0] wr_code;

    assign above    = (acc_q >= L_A);
    assign below    = (acc_q < NEG_L_A);
    assign at_limit = (k_q == K_MAX) || (k_q == K_MIN);
    assign sat_hit  = at_limit && (above || below);

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        sat_pend_d = sat_pend_q;
        sat_d      = sat_q;
        fv_d       = 1'b0;
        acc_d      = acc_q;
        k_d        = k_q;
        buf_code_d = buf_code_q;
        buf_k_d    = buf_k_q;
        out_d      = out_q;
        k_out_d    = k_out_q;
        in_ready   = 1'b0;
        wr         = 1'b0;
        wr_code    = '0;

        case (state_q)
            S_IDLE: begin
                // Holding reset keeps the handshake closed so nothing is
                // accepted in a cycle whose state is about to be discarded.
                in_ready = en && !reset;
                if (in_valid && in_ready) begin
                    acc_d   = {{2{in_sample[IN_RES-1]}}, in_sample};
                    k_d     = '0;
                    state_d = S_FOLD;
                end
            end
            S_FOLD: begin
                if (sat_hit) begin
                    // k is already +/-MAX_FOLDS here, so it is written as is.
                    wr      = 1'b1;
                    wr_code = clip_code(above);
                    state_d = S_IDLE;
                end else if (above) begin
                    acc_d = acc_q - TWO_L_A;
                    k_d   = k_q + K_ONE;
                end else if (below) begin
                    acc_d = acc_q + TWO_L_A;
                    k_d   = k_q - K_ONE;
                end else begin
                    wr      = 1'b1;
                    wr_code = offset_code(acc_q);
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (wr) begin
            buf_code_d[idx_q] = wr_code;
            buf_k_d[idx_q]    = k_q;
            if (idx_q == LAST_IDX) begin
                // The frame snapshot includes the write made in this cycle.
                out_d      = buf_code_d;
                k_out_d    = buf_k_d;
                sat_d      = sat_pend_q || sat_hit;
                sat_pend_d = 1'b0;
                idx_d      = '0;
                fv_d       = 1'b1;
            end else begin
                sat_pend_d = sat_pend_q || sat_hit;
                idx_d      = idx_q + IDX_W'(1);
            end
        end
    end

    // Control registers and the presented frame, which must read back as zero
    // after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            sat_pend_q <= 1'b0;
            sat_q      <= 1'b0;
            fv_q       <= 1'b0;
            out_q      <= '0;
            k_out_q    <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            sat_pend_q <= sat_pend_d;
            sat_q      <= sat_d;
            fv_q       <= fv_d;
            out_q      <= out_d;
            k_out_q    <= k_out_d;
        end
    end

    // Working datapath: every buffer slot is rewritten before the next frame
    // snapshot, and acc/k are loaded on acceptance, so no reset is needed.
    always_ff @(posedge clk) begin
        acc_q      <= acc_d;
        k_q        <= k_d;
        buf_code_q <= buf_code_d;
        buf_k_q    <= buf_k_d;
    end

    assign out         = out_q;
    assign k_out       = k_out_q;
    assign frame_valid = fv_q;
    assign sat         = sat_q;

endmodule

// File: tb/tb_usf_modulo_folder.sv
// -----------------------------------------------------------------------------
// tb_usf_modulo_folder
//
// Directed bench for usf_modulo_folder with default parameters (L=1024,
// FRAME_LEN=8, MAX_FOLDS=15). Each frame is described by input samples and
// hand-computed codes and fold counts.
// -----------------------------------------------------------------------------
module tb_usf_modulo_folder;

    logic               clk;
    logic               reset;
    logic               en;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] in_sample;
    logic        [7:0][11:0] out;
    logic signed [7:0][4:0]  k_out;
    logic               frame_valid;
    logic               sat;

    int nvec = 0;
    int nerr = 0;
    int fv_cnt = 0;

    int ys[8];
    int ec[8];
    int ek[8];

    usf_modulo_folder dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sample  (in_sample),
        .out        (out),
        .k_out      (k_out),
        .frame_valid(frame_valid),
        .sat        (sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (frame_valid) fv_cnt++;

    task automatic chk(input string tag, input int got, input int exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Offer one sample, then count cycles until in_ready returns (2+|k|).
    task automatic push(input int y, input int exp_lat, input string tag);
        int c;
        c = 0;
        @(negedge clk);
        while (!in_ready && c < 100) begin
            @(negedge clk);
            c++;
        end
        if (!in_ready) chk({tag, "_accept_timeout"}, 0, 1);
        in_valid  = 1'b1;
        in_sample = 16'(y);
        @(negedge clk);
        in_valid  = 1'b0;
        in_sample = 16'sh5a5a;
        c = 1;
        while (!in_ready && c < 100) begin
            @(negedge clk);
            c++;
        end
        chk({tag, "_lat"}, c, exp_lat);
    endtask

    // Push ys[first..7] and check the resulting frame against ec/ek.
    task automatic run_frame(input int first, input int exp_sat, input string tag);
        for (int i = first; i < 8; i++)
            push(ys[i], 2 + ((ek[i] < 0) ? -ek[i] : ek[i]), $sformatf("%s_s%0d", tag, i));
        chk({tag, "_fv_pulse"}, int'(frame_valid), 1);
        @(negedge clk);
        chk({tag, "_fv_drop"}, int'(frame_valid), 0);
        chk({tag, "_sat"}, int'(sat), exp_sat);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("%s_code%0d", tag, i), int'(out[i]), ec[i]);
            chk($sformatf("%s_k%0d", tag, i), int'($signed(k_out[i])), ek[i]);
        end
    endtask

    initial begin
        int fv0;
        logic seen;

        reset     = 1'b1;
        en        = 1'b1;
        in_valid  = 1'b0;
        in_sample = '0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_fv", int'(frame_valid), 0);
        chk("rst_sat", int'(sat), 0);
        chk("rst_out0", int'(out[0]), 0);
        chk("rst_k7", int'($signed(k_out[7])), 0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", int'(in_ready), 1);

        // Basic folds and range boundaries
        ys = '{300, 2500, -1025, 1024, -1024, 1023, 0, 500};
        ec = '{1324, 1476, 2047, 0, 0, 2047, 1024, 1524};
        ek = '{0, 1, -1, 1, 0, 0, 0, 0};
        run_frame(0, 0, "basic");

        // Saturation in both directions
        ys = '{32767, -32768, 100, 0, 0, 0, 0, 0};
        ec = '{2047, 0, 1124, 1024, 1024, 1024, 1024, 1024};
        ek = '{15, -15, 0, 0, 0, 0, 0, 0};
        run_frame(0, 1, "satf");

        // Ramp, all in range after folding: exactly one pulse, sat clears
        fv0 = fv_cnt;
        ys = '{0, 500, 1000, 1500, 2000, 2500, 3000, 3500};
        ec = '{1024, 1524, 2024, 476, 976, 1476, 1976, 428};
        ek = '{0, 0, 0, 1, 1, 1, 1, 2};
        run_frame(0, 0, "ramp");
        chk("ramp_one_pulse", fv_cnt - fv0, 1);

        // Partial next frame: the presented frame must hold
        push(10, 2, "part0");
        push(20, 2, "part1");
        push(30, 2, "part2");
        chk("hold_out0", int'(out[0]), 1024);
        chk("hold_out7", int'(out[7]), 428);
        chk("hold_k7", int'($signed(k_out[7])), 2);
        chk("hold_no_pulse", fv_cnt - fv0, 1);

        // en low with in_valid held: nothing may be accepted
        en        = 1'b0;
        in_valid  = 1'b1;
        in_sample = 16'sd77;
        seen      = 1'b0;
        repeat (6) begin
            @(negedge clk);
            seen = seen | in_ready;
        end
        chk("en0_no_ready", int'(seen), 0);
        in_valid = 1'b0;

        // en drops while a sample is folding: it still completes
        en = 1'b1;
        @(negedge clk);
        chk("endrop_ready", int'(in_ready), 1);
        in_valid  = 1'b1;
        in_sample = 16'sd2500;
        @(negedge clk);
        in_valid = 1'b0;
        en       = 1'b0;
        repeat (4) @(negedge clk);
        chk("endrop_gated", int'(in_ready), 0);
        en = 1'b1;
        @(negedge clk);
        chk("endrop_done", int'(in_ready), 1);

        ys = '{10, 20, 30, 2500, 40, 50, 60, 70};
        ec = '{1034, 1044, 1054, 1476, 1064, 1074, 1084, 1094};
        ek = '{0, 0, 0, 1, 0, 0, 0, 0};
        run_frame(4, 0, "endrop");

        // Reset after 5 samples discards the partial frame
        for (int i = 0; i < 5; i++) push(i + 1, 2, $sformatf("pre_rst%0d", i));
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_ready", int'(in_ready), 0);
        @(negedge clk);
        chk("mid_rst_out0", int'(out[0]), 0);
        chk("mid_rst_fv", int'(frame_valid), 0);
        reset = 1'b0;

        ys = '{-1, -2, -3, -4, -5, -6, -7, -8};
        ec = '{1023, 1022, 1021, 1020, 1019, 1018, 1017, 1016};
        ek = '{0, 0, 0, 0, 0, 0, 0, 0};
        run_frame(0, 0, "fresh");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
